// File: rtl/branch_pred_pkg.sv
// Shared definitions for the branch predictor: jump opcodes, counter states,
// and the decode / counter-step helpers.
package branch_pred_pkg;

  localparam logic [4:0] JC1 = 5'b10000;
  localparam logic [4:0] JN1 = 5'b01000;
  localparam logic [4:0] JV1 = 5'b00100;
  localparam logic [4:0] JZ1 = 5'b00010;
  localparam logic [4:0] JC0 = 5'b01110;
  localparam logic [4:0] JN0 = 5'b10110;
  localparam logic [4:0] JV0 = 5'b11010;
  localparam logic [4:0] JZ0 = 5'b11100;

  // Bit 1 set means "lean not-taken", so prediction is simply ~cnt[1].
  typedef enum logic [1:0] {
    S_T  = 2'b00,
    W_T  = 2'b01,
    W_NT = 2'b10,
    S_NT = 2'b11
  } cnt_t;

  // Returns {isCond, taken}; flags are C=[11], N=[10], V=[9], Z=[8].
  function automatic logic [1:0] jump_taken(input logic [4:0] jumpType,
                                            input logic [11:0] statusBits);
    logic c, n, v, z;
    c = statusBits[11];
    n = statusBits[10];
    v = statusBits[9];
    z = statusBits[8];
    case (jumpType)
      JC1:     jump_taken = {1'b1, c};
      JN1:     jump_taken = {1'b1, n};
      JV1:     jump_taken = {1'b1, v};
      JZ1:     jump_taken = {1'b1, z};
      JC0:     jump_taken = {1'b1, ~c};
      JN0:     jump_taken = {1'b1, ~n};
      JV0:     jump_taken = {1'b1, ~v};
      JZ0:     jump_taken = {1'b1, ~z};
      default: jump_taken = 2'b00;
    endcase
  endfunction

  function automatic cnt_t cnt_next(input cnt_t cnt, input logic taken);
    cnt_next = cnt;
    if (taken) begin
      case (cnt)
        S_NT:    cnt_next = W_NT;
        W_NT:    cnt_next = W_T;
        default: cnt_next = S_T;
      endcase
    end else begin
      case (cnt)
        S_T:     cnt_next = W_T;
        W_T:     cnt_next = W_NT;
        default: cnt_next = S_NT;
      endcase
    end
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One 2-bit saturating direction counter; load wins over update.
module bp_sat_counter
  import branch_pred_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  cnt_t loadValue,
  input  logic update,
  input  logic taken,
  output cnt_t cnt
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= W_T;
    end else if (load) begin
      cnt <= loadValue;
    end else if (update) begin
      cnt <= cnt_next(cnt, taken);
    end
  end

endmodule

// File: rtl/branch_pred_btb.sv
// Fully-associative tagged branch predictor with separate lookup and resolve
// ports, round-robin allocation on resolve miss, and saturating statistics.
module branch_pred_btb
  import branch_pred_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int ENTRIES = 8,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              pred_valid,
  output logic              pred_hit,
  output logic              pred_taken,
  input  logic              resolve_valid,
  input  logic [ADDR_W-1:0] resolve_addr,
  input  logic [4:0]        jump_type,
  input  logic [11:0]       status_bits,
  input  logic              resolve_pred,
  output logic              resolve_done,
  output logic              actual_taken,
  output logic              mispredict,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] mispred_count
);

  localparam int PTR_W = $clog2(ENTRIES);

  logic [ADDR_W-1:0] tagMem [ENTRIES];
  logic [ENTRIES-1:0] validMem;
  cnt_t cntMem [ENTRIES];
  logic [PTR_W-1:0] allocPtr;

  logic [ENTRIES-1:0] lookupMatch, resolveMatch, cntLoad, cntUpdate;
  logic lookupHit, lookupTaken;
  logic resolveHit, resolveCond, resolveTaken, tableWrite, resolveMiss;
  cnt_t allocValue;
  logic unusedStatus;

  assign unusedStatus = ^status_bits[7:0];

  // Tags are unique, so the per-entry matches are one-hot and can be OR-reduced.
  always_comb begin
    lookupMatch = '0;
    lookupTaken = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      lookupMatch[i] = validMem[i] && (tagMem[i] == lookup_addr);
      if (lookupMatch[i] && !cntMem[i][1]) lookupTaken = 1'b1;
    end
    lookupHit = |lookupMatch;
  end

  always_comb begin
    {resolveCond, resolveTaken} = jump_taken(jump_type, status_bits);
    resolveMatch = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      resolveMatch[i] = validMem[i] && (tagMem[i] == resolve_addr);
    end
    resolveHit  = |resolveMatch;
    tableWrite  = resolve_valid && resolveCond;
    resolveMiss = tableWrite && !resolveHit;
    allocValue  = resolveTaken ? W_T : W_NT;
    cntUpdate   = (tableWrite && resolveHit) ? resolveMatch : '0;
    cntLoad     = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      cntLoad[i] = resolveMiss && (allocPtr == PTR_W'(i));
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : gCnt
    bp_sat_counter uCnt (
      .clk       (clk),
      .resetn    (resetn),
      .load      (cntLoad[g]),
      .loadValue (allocValue),
      .update    (cntUpdate[g]),
      .taken     (resolveTaken),
      .cnt       (cntMem[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      validMem <= '0;
      allocPtr <= '0;
    end else if (resolveMiss) begin
      validMem[allocPtr] <= 1'b1;
      allocPtr           <= allocPtr + 1'b1;
    end
  end

  // Tags need no reset: they are qualified by validMem.
  always_ff @(posedge clk) begin
    if (resolveMiss) tagMem[allocPtr] <= resolve_addr;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pred_valid <= 1'b0;
      pred_hit   <= 1'b0;
      pred_taken <= 1'b0;
      hit_count  <= '0;
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        pred_hit   <= lookupHit;
        pred_taken <= lookupHit ? lookupTaken : 1'b1;
        if (lookupHit && (hit_count != {STAT_W{1'b1}})) hit_count <= hit_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resolve_done  <= 1'b0;
      actual_taken  <= 1'b0;
      mispredict    <= 1'b0;
      mispred_count <= '0;
    end else begin
      resolve_done <= resolve_valid;
      if (resolve_valid) begin
        actual_taken <= resolveCond && resolveTaken;
        mispredict   <= resolveCond && (resolveTaken != resolve_pred);
        if (resolveCond && (resolveTaken != resolve_pred) &&
            (mispred_count != {STAT_W{1'b1}})) begin
          mispred_count <= mispred_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_pred_btb.sv
// Directed table-driven bench for branch_pred_btb, with a second instance at
// STAT_W=2 sharing the stimulus to exercise statistics saturation.
module tb_branch_pred_btb;
  import branch_pred_pkg::*;

  typedef struct {
    logic lv; logic [7:0] la;
    logic rv; logic [7:0] ra; logic [4:0] jt; logic [11:0] sb; logic rp;
    logic pv; logic ph; logic pt;
    logic rd; logic at; logic mp;
    int hc; int mc;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic lookup_valid = 1'b0, resolve_valid = 1'b0, resolve_pred = 1'b0;
  logic [7:0] lookup_addr = '0, resolve_addr = '0;
  logic [4:0] jump_type = '0;
  logic [11:0] status_bits = '0;
  logic pred_valid, pred_hit, pred_taken, resolve_done, actual_taken, mispredict;
  logic [15:0] hit_count, mispred_count;
  logic satPv, satPh, satPt, satRd, satAt, satMp;
  logic [1:0] satHc, satMc;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  branch_pred_btb #(.ADDR_W(8), .ENTRIES(8), .STAT_W(16)) dut (
    .clk(clk), .resetn(resetn),
    .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .resolve_valid(resolve_valid), .resolve_addr(resolve_addr),
    .jump_type(jump_type), .status_bits(status_bits), .resolve_pred(resolve_pred),
    .resolve_done(resolve_done), .actual_taken(actual_taken), .mispredict(mispredict),
    .hit_count(hit_count), .mispred_count(mispred_count)
  );

  branch_pred_btb #(.ADDR_W(8), .ENTRIES(8), .STAT_W(2)) dutSat (
    .clk(clk), .resetn(resetn),
    .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
    .pred_valid(satPv), .pred_hit(satPh), .pred_taken(satPt),
    .resolve_valid(resolve_valid), .resolve_addr(resolve_addr),
    .jump_type(jump_type), .status_bits(status_bits), .resolve_pred(resolve_pred),
    .resolve_done(satRd), .actual_taken(satAt), .mispredict(satMp),
    .hit_count(satHc), .mispred_count(satMc)
  );

  function automatic vec_t mkVec(logic lv, logic [7:0] la, logic rv, logic [7:0] ra,
                                 logic [4:0] jt, logic [11:0] sb, logic rp,
                                 logic pv, logic ph, logic pt,
                                 logic rd, logic at, logic mp, int hc, int mc);
    vec_t v;
    v.lv = lv; v.la = la; v.rv = rv; v.ra = ra; v.jt = jt; v.sb = sb; v.rp = rp;
    v.pv = pv; v.ph = ph; v.pt = pt; v.rd = rd; v.at = at; v.mp = mp;
    v.hc = hc; v.mc = mc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    lookup_valid = v.lv; lookup_addr = v.la;
    resolve_valid = v.rv; resolve_addr = v.ra; jump_type = v.jt;
    status_bits = v.sb; resolve_pred = v.rp;
    @(posedge clk);
    #1;
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    checkOutput({tag, " pred_valid"}, int'(pred_valid), int'(v.pv));
    checkOutput({tag, " pred_hit"}, int'(pred_hit), int'(v.ph));
    checkOutput({tag, " pred_taken"}, int'(pred_taken), int'(v.pt));
    checkOutput({tag, " resolve_done"}, int'(resolve_done), int'(v.rd));
    checkOutput({tag, " actual_taken"}, int'(actual_taken), int'(v.at));
    checkOutput({tag, " mispredict"}, int'(mispredict), int'(v.mp));
    checkOutput({tag, " hit_count"}, int'(hit_count), v.hc);
    checkOutput({tag, " mispred_count"}, int'(mispred_count), v.mc);
    checkOutput({tag, " sat hit_count"}, int'(satHc), (v.hc > 3) ? 3 : v.hc);
    checkOutput({tag, " sat mispred_count"}, int'(satMc), (v.mc > 3) ? 3 : v.mc);
  endtask

  initial begin
    // Directed sequence; expected values are the outputs right after each edge.
    vecs.push_back(mkVec(1, 8'h3A, 0, 0, 0, 0, 0,              1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 1, 8'h3A, JZ0, 12'h100, 1,      0, 0, 1, 1, 0, 1, 0, 1));
    vecs.push_back(mkVec(1, 8'h3A, 0, 0, 0, 0, 0,              1, 1, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mkVec(0, 0, 1, 8'h3A, JC1, 12'h800, 0,      0, 1, 0, 1, 1, 1, 1, 2));
    vecs.push_back(mkVec(0, 0, 1, 8'h3A, JC1, 12'h800, 1,      0, 1, 0, 1, 1, 0, 1, 2));
    vecs.push_back(mkVec(1, 8'h3A, 1, 8'h3A, JC1, 12'h800, 1,  1, 1, 1, 1, 1, 0, 2, 2));
    vecs.push_back(mkVec(1, 8'h3A, 1, 8'h3A, JZ1, 12'h000, 0,  1, 1, 1, 1, 0, 0, 3, 2));
    vecs.push_back(mkVec(1, 8'h3A, 0, 0, 0, 0, 0,              1, 1, 1, 0, 0, 0, 4, 2));
    vecs.push_back(mkVec(0, 0, 1, 8'h3A, JC0, 12'h800, 1,      0, 1, 1, 1, 0, 1, 4, 3));
    vecs.push_back(mkVec(1, 8'h3A, 1, 8'h3A, JN1, 12'h400, 0,  1, 1, 0, 1, 1, 1, 5, 4));
    vecs.push_back(mkVec(1, 8'h3A, 0, 0, 0, 0, 0,              1, 1, 1, 0, 1, 1, 6, 4));
    vecs.push_back(mkVec(0, 0, 1, 8'h3A, 5'b00000, 12'hFFF, 1, 0, 1, 1, 1, 0, 0, 6, 4));
    vecs.push_back(mkVec(1, 8'h3A, 1, 8'h55, 5'b11111, 12'hFFF, 1, 1, 1, 1, 1, 0, 0, 7, 4));
    vecs.push_back(mkVec(1, 8'h55, 0, 0, 0, 0, 0,              1, 0, 1, 0, 0, 0, 7, 4));
    for (int k = 0; k < 9; k++) begin
      vecs.push_back(mkVec(0, 0, 1, 8'(8'h10 + k), JV1, 12'h200, 1, 0, 0, 1, 1, 1, 0, 7, 4));
    end
    vecs.push_back(mkVec(1, 8'h10, 0, 0, 0, 0, 0,              1, 0, 1, 0, 1, 0, 7, 4));
    vecs.push_back(mkVec(1, 8'h11, 0, 0, 0, 0, 0,              1, 1, 1, 0, 1, 0, 8, 4));
    vecs.push_back(mkVec(1, 8'h18, 0, 0, 0, 0, 0,              1, 1, 1, 0, 1, 0, 9, 4));
    vecs.push_back(mkVec(1, 8'h3A, 0, 0, 0, 0, 0,              1, 0, 1, 0, 1, 0, 9, 4));
    vecs.push_back(mkVec(1, 8'h17, 0, 0, 0, 0, 0,              1, 1, 1, 0, 1, 0, 10, 4));
    vecs.push_back(mkVec(0, 0, 1, 8'h11, JN0, 12'h000, 1,      0, 1, 1, 1, 1, 0, 10, 4));
    vecs.push_back(mkVec(0, 0, 1, 8'h12, JV0, 12'h200, 0,      0, 1, 1, 1, 0, 0, 10, 4));
    vecs.push_back(mkVec(1, 8'h12, 0, 0, 0, 0, 0,              1, 1, 0, 0, 0, 0, 11, 4));
    vecs.push_back(mkVec(0, 0, 1, 8'h12, JZ1, 12'h100, 0,      0, 1, 0, 1, 1, 1, 11, 5));
    vecs.push_back(mkVec(1, 8'h12, 0, 0, 0, 0, 0,              1, 1, 1, 0, 1, 1, 12, 5));
    vecs.push_back(mkVec(0, 0, 1, 8'h13, JC1, 12'h000, 1,      0, 1, 1, 1, 0, 1, 12, 6));

    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkVector(-1, mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    resetn = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end

    // Reset arriving while both ports are busy drops the in-flight requests.
    resetn = 1'b1;
    applyStimulus(mkVec(1, 8'h11, 1, 8'h11, JC1, 12'h800, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("prereset pred_valid", int'(pred_valid), 1);
    resetn = 1'b0;
    applyStimulus(mkVec(1, 8'h11, 1, 8'h11, JC1, 12'h800, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkVector(100, mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    resetn = 1'b1;
    applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("postreset pred_valid", int'(pred_valid), 0);
    checkOutput("postreset resolve_done", int'(resolve_done), 0);
    applyStimulus(mkVec(1, 8'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("postreset lookup pred_valid", int'(pred_valid), 1);
    checkOutput("postreset lookup pred_hit", int'(pred_hit), 0);
    checkOutput("postreset lookup pred_taken", int'(pred_taken), 1);
    checkOutput("postreset hit_count", int'(hit_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
